// File: rtl/fp_pkg.sv
// Shared IEEE 754 single-precision definitions for the PE floating-point datapath.
package fp_pkg;

  localparam int BIAS  = 127;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  // Magnitude bits of infinity: exponent all ones, mantissa zero.
  localparam logic [30:0] FP_INF_MAG = 31'h7F800000;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] fp_man(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fp_div_pack.sv
// Combinational normalise / overflow / underflow / pack of a divider quotient.
// The quotient q holds 1 integer bit (q[24]) and 24 fraction bits; since both
// mantissas lie in [1,2) the quotient lies in (0.5,2), so at most one
// left shift is needed to normalise.
module fp_div_pack
  import fp_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,
  input  logic [24:0]       q_i,
  output logic [31:0]       result_o
);

  logic signed [9:0] exp_adj;
  logic [MAN_W-1:0]  man;

  // Select the mantissa window, adjust the exponent, then saturate or flush.
  always_comb begin
    if (q_i[24]) begin
      exp_adj = exp_i;
      man     = q_i[23:1];
    end else begin
      exp_adj = exp_i - 10'sd1;
      man     = q_i[22:0];
    end
    if (exp_adj >= 10'sd255) begin
      result_o = {sign_i, FP_INF_MAG};
    end else if (exp_adj <= 10'sd0) begin
      result_o = {sign_i, 31'h0};
    end else begin
      result_o = {sign_i, exp_adj[7:0], man};
    end
  end

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential IEEE 754 single-precision divider, restoring radix-2, one
// quotient bit per clock.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE (and never while rst is high);
// out_valid is high only in DONE and result/div_by_zero are held stable until
// the edge where out_ready is also high. Ready never depends on the same
// cycle's valid of the other side.
module fp_divider_seq
  import fp_pkg::*;
#(
  parameter int ITER = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        div_by_zero,
  output state_t      dbg_state
);

  state_t            state_q;
  logic [4:0]        cnt_q;
  logic [25:0]       rem_q;
  logic [25:0]       rem_d;
  logic [ITER-1:0]   quo_q;
  logic [ITER-1:0]   quo_d;
  logic [23:0]       mb_q;
  logic signed [9:0] exp_q;
  logic signed [9:0] exp_acc;
  logic              sign_q;
  logic              zdiv_q;
  logic              zop_q;
  logic [31:0]       result_q;
  logic              dbz_q;
  logic              out_valid_q;
  logic              rem_ge;
  logic              accept;
  logic [31:0]       packed_res;

  assign in_ready    = (state_q == IDLE) && !rst;
  assign accept      = in_valid && in_ready;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

  // Biased exponent difference, kept signed and wide enough for over/underflow.
  assign exp_acc = {2'b00, fp_exp(a)} - {2'b00, fp_exp(b)} + 10'(BIAS);

  // One restoring step: trial subtract, keep on success, shift left.
  always_comb begin
    rem_ge = (rem_q >= {2'b00, mb_q});
    rem_d  = (rem_ge ? (rem_q - {2'b00, mb_q}) : rem_q) << 1;
    quo_d  = {quo_q[ITER-2:0], rem_ge};
  end

  fp_div_pack u_pack (
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .q_i      (quo_q),
    .result_o (packed_res)
  );

  // Control FSM with datapath registers; special cases skip the quotient loop
  // and use the NORM slot, so every result is written on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      mb_q        <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      zdiv_q      <= 1'b0;
      zop_q       <= 1'b0;
      result_q    <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sign_q <= fp_sign(a) ^ fp_sign(b);
            rem_q  <= {2'b00, 1'b1, fp_man(a)};
            mb_q   <= {1'b1, fp_man(b)};
            exp_q  <= exp_acc;
            quo_q  <= '0;
            cnt_q  <= '0;
            zdiv_q <= (fp_exp(b) == '0);
            zop_q  <= (fp_exp(a) == '0);
            if ((fp_exp(b) == '0) || (fp_exp(a) == '0)) begin
              state_q <= NORM;
            end else begin
              dbz_q   <= 1'b0;
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == 5'(ITER - 1)) begin
            cnt_q   <= '0;
            state_q <= NORM;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        NORM: begin
          if (zdiv_q) begin
            result_q <= {sign_q, FP_INF_MAG};
            dbz_q    <= 1'b1;
          end else if (zop_q) begin
            result_q <= {sign_q, 31'h0};
            dbz_q    <= 1'b0;
          end else begin
            result_q <= packed_res;
            dbz_q    <= 1'b0;
          end
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed testbench for fp_divider_seq: hand-computed vectors, latency,
// backpressure, turnaround and mid-operation reset.
module tb_fp_divider_seq;
  import fp_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_by_zero;
  state_t      dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  fp_divider_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Issue one operation, measure latency, hold the result for 'hold' cycles
  // under backpressure (pulsing in_valid), then complete the output handshake.
  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_res, input logic exp_dbz,
                       input int exp_lat, input int hold);
    int wait_cyc;
    int lat;
    logic [31:0] exp_res_sb;
    exp_q.push_back(exp_res);
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk({tag, "_in_ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = '0;
    b = '0;
    chk({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    exp_res_sb = exp_q.pop_front();
    chk({tag, "_result"}, result, exp_res_sb);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      a = 32'h40A00000;
      b = 32'h00000000;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_bp_result"}, result, exp_res_sb);
      chk({tag, "_bp_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
      chk({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_bp_out_valid"}, 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_release_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int ov_seen;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Main vectors
    do_op("div_6_2",   32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26, 0);
    do_op("div_1_3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26, 0);
    do_op("div_m6_2",  32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 26, 0);
    do_op("div_5_0",   32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1, 1, 0);
    do_op("overflow",  32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 26, 0);
    do_op("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 26, 0);
    do_op("zero_a",    32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1, 0);
    do_op("m5_0",      32'hC0A00000, 32'h00000000, 32'hFF800000, 1'b1, 1, 0);
    do_op("zero_by_0", 32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, 1, 0);
    // Backpressure: hold result for 10 cycles
    do_op("bp_1_3",    32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26, 10);
    @(negedge clk);
    chk("bp_idle_after", 32'(dbg_state), 32'(IDLE));
    do_op("pre_rst_5_0", 32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1, 1, 0);

    // Reset at DIV iteration 12
    in_valid = 1'b1;
    a = 32'h40C00000;
    b = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("mid_state_div", 32'(dbg_state), 32'(DIV));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", result, 32'h0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    ov_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("abort_no_out_valid", 32'(ov_seen), 32'd0);
    do_op("fresh_6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
